// File: rtl/instr_memory.sv
// Purpose : program (instruction) memory for the CPU; combinational read port,
//           synchronous load port, asynchronous invalidate of every word.
// Latency : read is combinational (0 cycles); a load is visible after the posedge it is sampled on.
// Backpressure: none; a load is accepted every cycle and the read port is always available.
//
// Ports:
//   instr     (out, WORD_WIDTH) word at pointer, or 0 when the word is invalid or out of range
//   pointer   (in,  WORD_WIDTH) program pointer / read address, compared at full width
//   clk       (in,  1)          clock; all writes on the rising edge
//   reset     (in,  1)          asynchronous active-high; clears every valid bit
//   load_en   (in,  1)          write strobe
//   load_addr (in,  WORD_WIDTH) write address; addresses >= DEPTH are dropped
//   load_data (in,  WORD_WIDTH) word to write
module instr_memory #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_BITS  = 8
) (
    output logic [WORD_WIDTH-1:0] instr,
    input  logic [WORD_WIDTH-1:0] pointer,
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [WORD_WIDTH-1:0] load_addr,
    input  logic [WORD_WIDTH-1:0] load_data
);

    // DEPTH expressed at pointer width so the range check sees every pointer bit;
    // an out-of-range pointer can never alias onto a stored word.
    localparam logic [WORD_WIDTH-1:0] DEPTH_W = WORD_WIDTH'(DEPTH);

    // Data words carry no reset: a word is only observable through its valid bit.
    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;

    logic                  rd_in_range;
    logic [ADDR_BITS-1:0]  rd_idx;
    logic                  wr_in_range;
    logic                  wr_hit;
    logic [ADDR_BITS-1:0]  wr_idx;

    // ------------------------------------------------------------------
    // Read path (purely combinational)
    // ------------------------------------------------------------------
    assign rd_in_range = (pointer < DEPTH_W);
    assign rd_idx      = pointer[ADDR_BITS-1:0];

    // Default to NOP so neither an out-of-range pointer nor an unwritten
    // (possibly X) data word can reach instr.
    always_comb begin
        instr = '0;
        if (rd_in_range && valid_q[rd_idx]) begin
            instr = mem_q[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    assign wr_in_range = (load_addr < DEPTH_W);
    assign wr_idx      = load_addr[ADDR_BITS-1:0];
    assign wr_hit      = load_en && wr_in_range;

    always_comb begin
        valid_d = valid_q;
        if (wr_hit) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Reset only touches the valid bits. Holding them clear for the whole
    // reset interval is what makes loads during reset ineffective.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // A data word written while reset is high stays hidden behind its cleared
    // valid bit and must be reloaded, so the data array needs no reset gating.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem_q[wr_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_instr_memory.sv
module tb_instr_memory;

    localparam int WW    = 16;
    localparam int DEPTH = 256;

    logic [WW-1:0] instr;
    logic [WW-1:0] pointer;
    logic          clk;
    logic          reset;
    logic          load_en;
    logic [WW-1:0] load_addr;
    logic [WW-1:0] load_data;

    // Stands in for the register inside instr_fetch.
    logic [WW-1:0] fetch_q;

    int checks;
    int failures;

    instr_memory #(
        .WORD_WIDTH (WW),
        .DEPTH      (DEPTH),
        .ADDR_BITS  (8)
    ) dut (
        .instr     (instr),
        .pointer   (pointer),
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) fetch_q <= instr;

    // Single write, presented at a falling edge, captured by the following posedge.
    task automatic do_write(input logic [WW-1:0] a, input logic [WW-1:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk);
        #1;
        load_en   = 1'b0;
    endtask

    task automatic test_reset;
        logic [WW-1:0] ptrs [3];
        ptrs[0] = 16'd0;
        ptrs[1] = 16'd5;
        ptrs[2] = 16'd255;
        for (int i = 0; i < 3; i++) begin
            pointer = ptrs[i];
            #1;
            checks++;
            if (instr !== 16'h0000) begin
                failures++;
                $display("FAIL reset_read ptr=%0d instr=%h expected=0000", ptrs[i], instr);
            end
        end
    endtask

    task automatic test_load_read;
        @(negedge clk);
        reset = 1'b0;
        // Two loads on consecutive edges.
        @(negedge clk);
        load_en = 1'b1; load_addr = 16'd0; load_data = 16'h1234;
        @(negedge clk);
        load_addr = 16'd1; load_data = 16'hBEEF;
        @(negedge clk);
        load_en = 1'b0;
        pointer = 16'd0;
        #1;
        checks++;
        if (instr !== 16'h1234) begin
            failures++;
            $display("FAIL load_read_0 instr=%h expected=1234", instr);
        end
        pointer = 16'd1;
        #1;
        checks++;
        if (instr !== 16'hBEEF) begin
            failures++;
            $display("FAIL load_read_1 instr=%h expected=beef", instr);
        end
    endtask

    task automatic test_read_during_write;
        @(negedge clk);
        pointer = 16'd3;
        load_en = 1'b1; load_addr = 16'd3; load_data = 16'h00AA;
        #1;
        checks++;
        if (instr !== 16'h0000) begin
            failures++;
            $display("FAIL rdw_before_edge instr=%h expected=0000", instr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (instr !== 16'h00AA) begin
            failures++;
            $display("FAIL rdw_after_edge instr=%h expected=00aa", instr);
        end
        @(negedge clk);
        load_data = 16'h0055;
        #1;
        checks++;
        if (instr !== 16'h00AA) begin
            failures++;
            $display("FAIL rewrite_before_edge instr=%h expected=00aa", instr);
        end
        @(posedge clk);
        #1;
        load_en = 1'b0;
        checks++;
        if (instr !== 16'h0055) begin
            failures++;
            $display("FAIL rewrite_after_edge instr=%h expected=0055", instr);
        end
    endtask

    task automatic test_out_of_range;
        do_write(16'd256, 16'hFFFF);
        // 0x0103 would land on address 3 if the address were truncated.
        do_write(16'h0103, 16'hDEAD);
        pointer = 16'd256;
        #1;
        checks++;
        if (instr !== 16'h0000) begin
            failures++;
            $display("FAIL oor_read_256 instr=%h expected=0000", instr);
        end
        pointer = 16'h0103;
        #1;
        checks++;
        if (instr !== 16'h0000) begin
            failures++;
            $display("FAIL oor_read_0103 instr=%h expected=0000", instr);
        end
        pointer = 16'd0;
        #1;
        checks++;
        if (instr !== 16'h1234) begin
            failures++;
            $display("FAIL oor_addr0_kept instr=%h expected=1234", instr);
        end
        pointer = 16'd255;
        #1;
        checks++;
        if (instr !== 16'h0000) begin
            failures++;
            $display("FAIL oor_addr255_clean instr=%h expected=0000", instr);
        end
        pointer = 16'd3;
        #1;
        checks++;
        if (instr !== 16'h0055) begin
            failures++;
            $display("FAIL oor_no_alias instr=%h expected=0055", instr);
        end
    endtask

    task automatic test_async_reset;
        pointer = 16'd0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (instr !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset_drop instr=%h expected=0000", instr);
        end
        // Load pulse across an edge while reset is held.
        @(negedge clk);
        load_en = 1'b1; load_addr = 16'd0; load_data = 16'h9999;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        checks++;
        if (instr !== 16'h0000) begin
            failures++;
            $display("FAIL load_during_reset instr=%h expected=0000", instr);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (instr !== 16'h0000) begin
            failures++;
            $display("FAIL after_release_addr0 instr=%h expected=0000", instr);
        end
        pointer = 16'd1;
        #1;
        checks++;
        if (instr !== 16'h0000) begin
            failures++;
            $display("FAIL after_release_addr1 instr=%h expected=0000", instr);
        end
        // First write after release takes effect on the next edge.
        do_write(16'd0, 16'h4321);
        pointer = 16'd0;
        #1;
        checks++;
        if (instr !== 16'h4321) begin
            failures++;
            $display("FAIL first_write_after_release instr=%h expected=4321", instr);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        load_en = 1'b1; load_addr = 16'd7; load_data = 16'h1111;
        @(negedge clk);
        load_addr = 16'd8; load_data = 16'h8888;
        @(negedge clk);
        load_addr = 16'd7; load_data = 16'h2222;
        @(negedge clk);
        load_en = 1'b0;
        pointer = 16'd7;
        #1;
        checks++;
        if (instr !== 16'h2222) begin
            failures++;
            $display("FAIL b2b_overwrite instr=%h expected=2222", instr);
        end
        pointer = 16'd8;
        #1;
        checks++;
        if (instr !== 16'h8888) begin
            failures++;
            $display("FAIL b2b_neighbor instr=%h expected=8888", instr);
        end
    endtask

    task automatic test_fetch_sequence;
        // Reload 0..3 with 1..4 back to back.
        @(negedge clk);
        load_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_addr = WW'(i);
            load_data = WW'(i + 1);
            @(negedge clk);
        end
        load_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pointer = WW'(i);
            @(posedge clk);
            #1;
            checks++;
            if (fetch_q !== WW'(i + 1)) begin
                failures++;
                $display("FAIL fetch_seq step=%0d fetched=%h expected=%h", i, fetch_q, WW'(i + 1));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        pointer   = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        test_reset();
        test_load_read();
        test_read_during_write();
        test_out_of_range();
        test_async_reset();
        test_back_to_back();
        test_fetch_sequence();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
